// File: rtl/fifo_tb_pkg.sv
// Shared definitions for the FIFO traffic generator / checker pair.
//   gen_state_e    : generator FSM states
//   LFSR_TAPS/SEED : 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, never reaches 0
//   lfsr8_next     : one LFSR step (shift left, feedback into bit 0)
package fifo_tb_pkg;

  typedef enum logic [1:0] {IDLE, BURST, GAP, DONE} gen_state_e;

  localparam logic [7:0] LFSR_TAPS      = 8'hB8;
  localparam logic [7:0] LFSR_SEED      = 8'h01;
  localparam int         DEF_DATA_WIDTH = 8;

  // Taps at bits 7,5,4,3 of the left-shifting register realise the polynomial.
  function automatic logic [7:0] lfsr8_next(input logic [7:0] q);
    return {q[6:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/fifo_wr_gen_lfsr8.sv
// lfsr8: loadable, enable-stepped 8-bit Fibonacci LFSR.
// Clock/reset are generic so the read-side checker can run it on rclk.
//   clk, rst_n : clock, async active-low reset (resets to LFSR_SEED)
//   load, seed : synchronous load, has priority over en
//   en         : advance one step
//   q          : current LFSR value
module lfsr8
  import fifo_tb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       en,
  input  logic [7:0] seed,
  output logic [7:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    q <= LFSR_SEED;
    else if (load) q <= seed;
    else if (en)   q <= lfsr8_next(q);
  end

endmodule

// File: rtl/fifo_wr_gen.sv
// fifo_wr_gen: wclk-domain write-side traffic master for the dual-clock FIFO.
// Emits NUM_BURSTS bursts of BURST_LEN words (0 = run until stop), separated
// by GAP_CYCLES idle cycles, with counter or LFSR data, honouring wfull.
//   wclk, wrst_n : write clock, async active-low reset
//   start, stop  : run launch (IDLE/DONE only) / synchronous abort to IDLE
//   pat_sel      : 0 counter, 1 LFSR; latched at launch
//   wfull        : FIFO full flag
//   winc, wdata  : FIFO write request and data
//   busy, done   : in BURST/GAP, in DONE
//   word_cnt     : words accepted since the last launch
module fifo_wr_gen
  import fifo_tb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BURST_LEN  = 20,
  parameter int GAP_CYCLES = 4,
  parameter int NUM_BURSTS = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  pat_sel,
  input  logic                  wfull,
  output logic                  winc,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  word_cnt
);

  gen_state_e            state, state_nxt;
  logic [31:0]           beat, gap_cnt, burst_idx;
  logic                  pat_q;
  logic [DATA_WIDTH-1:0] cnt_q;
  logic [7:0]            lfsr_q;
  logic                  accept, last_beat, last_burst, gap_end, launch;

  assign winc       = (state == BURST) & ~wfull;
  assign accept     = winc;
  assign last_beat  = (beat == 32'(BURST_LEN - 1));
  assign last_burst = (NUM_BURSTS != 0) && (burst_idx + 32'd1 == 32'(NUM_BURSTS));
  assign gap_end    = (gap_cnt == 32'(GAP_CYCLES - 1));
  assign launch     = start & ~stop & ((state == IDLE) | (state == DONE));

  assign busy  = (state == BURST) | (state == GAP);
  assign done  = (state == DONE);
  // Both pattern sources are registers, so wdata is stable until accepted.
  assign wdata = pat_q ? DATA_WIDTH'(lfsr_q) : cnt_q;

  always_comb begin
    state_nxt = state;
    if (stop) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, DONE: if (start) state_nxt = BURST;
        BURST: if (accept && last_beat) begin
          if (last_burst)           state_nxt = DONE;
          else if (GAP_CYCLES != 0) state_nxt = GAP;
        end
        GAP:     if (gap_end) state_nxt = BURST;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state     <= IDLE;
      beat      <= '0;
      gap_cnt   <= '0;
      burst_idx <= '0;
      pat_q     <= 1'b0;
      cnt_q     <= '0;
      word_cnt  <= '0;
    end else begin
      state <= state_nxt;
      // An accept in the stop cycle still reached the FIFO, so it counts.
      if (accept) begin
        word_cnt <= word_cnt + 1'b1;
        cnt_q    <= cnt_q + 1'b1;
      end
      if (stop) begin
        beat      <= '0;
        gap_cnt   <= '0;
        burst_idx <= '0;
      end else if (launch) begin
        beat      <= '0;
        gap_cnt   <= '0;
        burst_idx <= '0;
        pat_q     <= pat_sel;
        cnt_q     <= '0;
        word_cnt  <= '0;
      end else begin
        if (accept) begin
          if (last_beat) begin
            beat      <= '0;
            burst_idx <= burst_idx + 32'd1;
          end else begin
            beat <= beat + 32'd1;
          end
        end
        // GAP is a pure cycle count; wfull has no effect here.
        if (state == GAP) gap_cnt <= gap_end ? '0 : gap_cnt + 32'd1;
      end
    end
  end

  lfsr8 u_lfsr (
    .clk   (wclk),
    .rst_n (wrst_n),
    .load  (launch),
    .en    (accept),
    .seed  (LFSR_SEED),
    .q     (lfsr_q)
  );

endmodule

// File: tb/tb_fifo_wr_gen.sv
// Bench for fifo_wr_gen: three instances with different shapes.
//   A: 3-word bursts, gap 4, 2 bursts (gap pattern, LFSR data)
//   B: 20-word single burst (counting, stall, stop)
//   C: 4-word bursts, 100 bursts, into a FIFO model drained on a 70 ns rclk
module tb_fifo_wr_gen;

  logic wclk = 1'b0, rclk = 1'b0;
  logic wrst_n = 1'b0, c_rst_n = 1'b0;
  initial forever #5 wclk = ~wclk;
  initial begin #2; forever #35 rclk = ~rclk; end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- instance A ----------------
  logic a_start = 0, a_stop = 0, a_pat = 0, a_wfull = 0;
  logic a_winc, a_busy, a_done;
  logic [7:0]  a_wdata;
  logic [15:0] a_wcnt;
  fifo_wr_gen #(.DATA_WIDTH(8), .BURST_LEN(3), .GAP_CYCLES(4), .NUM_BURSTS(2), .CNT_WIDTH(16)) u_a (
    .wclk(wclk), .wrst_n(wrst_n), .start(a_start), .stop(a_stop), .pat_sel(a_pat),
    .wfull(a_wfull), .winc(a_winc), .wdata(a_wdata), .busy(a_busy), .done(a_done),
    .word_cnt(a_wcnt));

  // ---------------- instance B ----------------
  logic b_start = 0, b_stop = 0, b_pat = 0, b_wfull = 0;
  logic b_winc, b_busy, b_done;
  logic [7:0]  b_wdata;
  logic [15:0] b_wcnt;
  fifo_wr_gen #(.DATA_WIDTH(8), .BURST_LEN(20), .GAP_CYCLES(4), .NUM_BURSTS(1), .CNT_WIDTH(16)) u_b (
    .wclk(wclk), .wrst_n(wrst_n), .start(b_start), .stop(b_stop), .pat_sel(b_pat),
    .wfull(b_wfull), .winc(b_winc), .wdata(b_wdata), .busy(b_busy), .done(b_done),
    .word_cnt(b_wcnt));

  // ---------------- instance C ----------------
  logic c_start = 0, c_stop = 0, c_pat = 0, c_wfull;
  logic c_winc, c_busy, c_done;
  logic [15:0] c_wdata;
  logic [15:0] c_wcnt;
  fifo_wr_gen #(.DATA_WIDTH(16), .BURST_LEN(4), .GAP_CYCLES(2), .NUM_BURSTS(100), .CNT_WIDTH(16)) u_c (
    .wclk(wclk), .wrst_n(c_rst_n), .start(c_start), .stop(c_stop), .pat_sel(c_pat),
    .wfull(c_wfull), .winc(c_winc), .wdata(c_wdata), .busy(c_busy), .done(c_done),
    .word_cnt(c_wcnt));

  // ---------------- scoreboards for A and B ----------------
  logic [7:0] qa[$], qb[$];

  // winc at a negedge means the word is accepted at the next posedge.
  always @(negedge wclk) begin
    if (wrst_n && a_winc) begin
      if (qa.size() == 0) chk("a_unexpected_write", {24'b0, a_wdata}, 32'hFFFF_FFFF);
      else                chk("a_wdata", {24'b0, a_wdata}, {24'b0, qa.pop_front()});
    end
    if (wrst_n && b_winc) begin
      if (qb.size() == 0) chk("b_unexpected_write", {24'b0, b_wdata}, 32'hFFFF_FFFF);
      else                chk("b_wdata", {24'b0, b_wdata}, {24'b0, qb.pop_front()});
    end
  end

  // ---------------- FIFO model for C ----------------
  logic [15:0] fq[$];
  int fcnt = 0;
  int rd_exp = 0;
  logic c_chk_en = 0;
  assign c_wfull = (fcnt >= 8);

  always @(negedge wclk) begin
    logic [15:0] w;
    if (c_rst_n && c_winc) begin
      w = c_wdata;
      @(posedge wclk);
      #1;
      if (c_rst_n) begin
        fq.push_back(w);
        fcnt++;
      end
    end
  end

  always @(posedge rclk) begin
    logic [15:0] v;
    #1;
    if (fcnt > 0) begin
      v = fq.pop_front();
      fcnt--;
      if (c_chk_en) begin
        chk("c_rd_seq", {16'b0, v}, rd_exp[31:0]);
        rd_exp++;
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [9:0] gap_pat;
    logic [7:0] lfsr_vec [6];

    // Reset values, checked while reset is held.
    #490;
    chk("a_rst_winc", a_winc, 0);  chk("a_rst_wdata", a_wdata, 0);
    chk("a_rst_busy", a_busy, 0);  chk("a_rst_done", a_done, 0);
    chk("a_rst_wcnt", a_wcnt, 0);
    chk("b_rst_winc", b_winc, 0);  chk("b_rst_wdata", b_wdata, 0);
    chk("b_rst_busy", b_busy, 0);  chk("b_rst_done", b_done, 0);
    chk("b_rst_wcnt", b_wcnt, 0);
    chk("c_rst_winc", c_winc, 0);  chk("c_rst_wdata", c_wdata, 0);
    chk("c_rst_wcnt", c_wcnt, 0);
    #10;
    wrst_n = 1; c_rst_n = 1;

    // B: one 20-word counting burst.
    for (int i = 0; i < 20; i++) qb.push_back(8'(i));
    @(posedge wclk); #1 b_start = 1; @(posedge wclk); #1 b_start = 0;
    for (int i = 0; i < 100 && !b_done; i++) @(negedge wclk);
    chk("b_t1_done", b_done, 1);   chk("b_t1_wcnt", b_wcnt, 20);
    chk("b_t1_busy", b_busy, 0);   chk("b_t1_winc", b_winc, 0);
    chk("b_t1_sb_empty", qb.size(), 0);

    // B: wfull high for 5 cycles after word 2 accepted; word 3 is held.
    for (int i = 0; i < 20; i++) qb.push_back(8'(i));
    @(posedge wclk); #1 b_start = 1; @(posedge wclk); #1 b_start = 0;
    repeat (3) @(posedge wclk);
    #1 b_wfull = 1;
    repeat (5) begin
      @(negedge wclk);
      chk("b_stall_winc", b_winc, 0);
      chk("b_stall_wdata", b_wdata, 3);
      chk("b_stall_wcnt", b_wcnt, 3);
      @(posedge wclk);
    end
    #1 b_wfull = 0;
    for (int i = 0; i < 100 && !b_done; i++) @(negedge wclk);
    chk("b_t2_done", b_done, 1);   chk("b_t2_wcnt", b_wcnt, 20);
    chk("b_t2_sb_empty", qb.size(), 0);

    // B: stop raised in the cycle the 7th word is accepted.
    for (int i = 0; i < 7; i++) qb.push_back(8'(i));
    @(posedge wclk); #1 b_start = 1; @(posedge wclk); #1 b_start = 0;
    repeat (6) @(posedge wclk);
    #1 b_stop = 1; @(posedge wclk); #1 b_stop = 0;
    @(negedge wclk);
    chk("b_stop_winc", b_winc, 0); chk("b_stop_busy", b_busy, 0);
    chk("b_stop_done", b_done, 0); chk("b_stop_wcnt", b_wcnt, 7);
    chk("b_stop_sb_empty", qb.size(), 0);
    for (int i = 0; i < 20; i++) qb.push_back(8'(i));
    @(posedge wclk); #1 b_start = 1; @(posedge wclk); #1 b_start = 0;
    @(negedge wclk);
    chk("b_restart_wcnt", b_wcnt, 0);
    for (int i = 0; i < 100 && !b_done; i++) @(negedge wclk);
    chk("b_t3_done", b_done, 1);   chk("b_t3_wcnt", b_wcnt, 20);
    chk("b_t3_sb_empty", qb.size(), 0);

    // A: two 3-word bursts with a 4-cycle gap, data 0..5.
    gap_pat = 10'b1110000111;
    for (int i = 0; i < 6; i++) qa.push_back(8'(i));
    @(posedge wclk); #1 a_start = 1; @(posedge wclk); #1 a_start = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge wclk);
      chk("a_gap_winc", a_winc, gap_pat[9-i]);
      chk("a_gap_busy", a_busy, 1);
    end
    @(negedge wclk);
    chk("a_gap_done", a_done, 1);  chk("a_gap_wcnt", a_wcnt, 6);
    chk("a_gap_sb_empty", qa.size(), 0);

    // A: LFSR run from DONE; a second start mid-burst must be ignored.
    lfsr_vec = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23};
    for (int i = 0; i < 6; i++) qa.push_back(lfsr_vec[i]);
    @(posedge wclk); #1 a_start = 1; a_pat = 1; @(posedge wclk); #1 a_start = 0; a_pat = 0;
    #1 a_start = 1; @(posedge wclk); #1 a_start = 0;
    for (int i = 0; i < 100 && !a_done; i++) @(negedge wclk);
    chk("a_lfsr_done", a_done, 1); chk("a_lfsr_wcnt", a_wcnt, 6);
    chk("a_lfsr_sb_empty", qa.size(), 0);

    // C: reset mid-burst, then 100 bursts through the slow-drained FIFO.
    @(posedge wclk); #1 c_start = 1; @(posedge wclk); #1 c_start = 0;
    repeat (30) @(negedge wclk);
    #2 c_rst_n = 0;
    #1;
    chk("c_mid_rst_winc", c_winc, 0);  chk("c_mid_rst_wdata", c_wdata, 0);
    chk("c_mid_rst_busy", c_busy, 0);  chk("c_mid_rst_done", c_done, 0);
    chk("c_mid_rst_wcnt", c_wcnt, 0);
    fq.delete(); fcnt = 0; rd_exp = 0; c_chk_en = 1;
    @(negedge wclk); #2 c_rst_n = 1;
    @(posedge wclk); #1 c_start = 1; @(posedge wclk); #1 c_start = 0;
    for (int i = 0; i < 20000 && !c_done; i++) @(negedge wclk);
    chk("c_done", c_done, 1);
    chk("c_wcnt", c_wcnt, 400);
    for (int i = 0; i < 2000 && fcnt != 0; i++) @(negedge wclk);
    repeat (10) @(negedge wclk);
    chk("c_rd_total", rd_exp[31:0], 400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
